// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding and
// the default operand width.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/seq_divider_ripple_subtractor.sv
// Combinational ripple-borrow subtractor built from full-subtractor cells;
// o_borrow is the borrow out of the MSB cell (set when i_a < i_b).
module ripple_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign o_diff[i]     = i_a[i] ^ i_b[i] ^ borrow[i];
        assign borrow[i + 1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & borrow[i]);
    end

    assign o_borrow = borrow[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with
// registered results, a divide-by-zero flag and a one-cycle done pulse.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [0:0]       state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // A restored remainder is always below the divisor, so its top bit is
    // never needed when shifting in the next dividend bit.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};

    ripple_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .i_a      (rem_shift),
        .i_b      ({1'b0, dvs}),
        .o_diff   (diff),
        .o_borrow (borrow)
    );

    assign rem_next = borrow ? rem_shift : diff;
    assign quo_next = {quo[WIDTH-2:0], ~borrow};
    assign o_busy   = (state == RUN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            count       <= '0;
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        // Divide by zero completes immediately without iterating.
                        if (i_divisor == '0) begin
                            o_quotient  <= '1;
                            o_remainder <= i_dividend;
                            o_div_zero  <= 1'b1;
                            o_done      <= 1'b1;
                        end else begin
                            quo   <= i_dividend;
                            dvs   <= i_divisor;
                            rem   <= '0;
                            count <= CW'(WIDTH);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    quo   <= quo_next;
                    rem   <= rem_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        o_quotient  <= quo_next;
                        o_remainder <= rem_next[WIDTH-1:0];
                        o_div_zero  <= 1'b0;
                        o_done      <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8) with hand-computed
// quotients, remainders and done/busy timing.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(
        .WIDTH(8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .o_busy      (busy),
        .o_done      (done),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle.
    // done_idx counts falling edges after the accepting rising edge.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_z, input int exp_idx, input int exp_busy);
        int busy_cycles;
        int done_idx;
        int overlap;
        busy_cycles = 0;
        done_idx    = 0;
        overlap     = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20 && done_idx == 0; k++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (busy) busy_cycles++;
            if (done) done_idx = k;
        end
        check({tag, "_done_idx"}, done_idx, exp_idx);
        check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        check({tag, "_overlap"}, overlap, 0);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        check({tag, "_dz"}, div_zero, exp_z);
    endtask

    initial begin
        int done_count;
        int done_idx;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_q", quotient, 0);
        check("reset_r", remainder, 0);
        check("reset_dz", div_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 8);
        @(negedge clk);
        check("hold_done_low", done, 0);
        check("hold_q", quotient, 14);
        check("hold_r", remainder, 2);

        run_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 8);
        run_op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, 8);
        run_op("d200_200", 8'd200, 8'd200, 8'd1, 8'd0, 1'b0, 9, 8);
        @(negedge clk);

        run_op("d37_0", 8'd37, 8'd0, 8'd255, 8'd37, 1'b1, 1, 0);
        @(negedge clk);
        run_op("d37_5", 8'd37, 8'd5, 8'd7, 8'd2, 1'b0, 9, 8);
        @(negedge clk);

        // Back-to-back: second start raised during the done cycle of the first
        run_op("b2b_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 8);
        check("b2b_done_at_start", done, 1);
        run_op("b2b_9_2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9, 8);
        @(negedge clk);
        run_op("prep_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, 8);
        @(negedge clk);

        // Start pulse with different operands while running must be ignored
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_count = 0;
        done_idx   = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (done) begin
                done_count++;
                if (done_idx == 0) done_idx = k;
            end
            if (busy) begin
                check("ign_q_stable", quotient, 0);
            end
            if (k == 3) begin
                dividend = 8'd50;
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == 9) begin
                check("ign_q", quotient, 14);
                check("ign_r", remainder, 2);
            end
        end
        check("ign_done_count", done_count, 1);
        check("ign_done_idx", done_idx, 9);
        check("ign_after_q", quotient, 14);

        // Asynchronous reset mid-run clears everything immediately
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_op("d17_4", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 9, 8);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
